// File: rtl/riscv_constants.sv
// Shared LSU constants: funct3 memory sizes, FSM states, exception causes, and lane helpers.
// Pure declarations; no latency or flow control of its own.
package riscv_constants;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    LSU_EXC_NONE           = 2'b00,
    LSU_EXC_LOAD_MISALIGN  = 2'b01,
    LSU_EXC_STORE_MISALIGN = 2'b10,
    LSU_EXC_ILLEGAL        = 2'b11
  } lsu_exc_e;

  // Illegal funct3 wins over misalignment.
  function automatic lsu_exc_e lsu_check(input logic we, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    logic legal;
    logic misal;
    legal = (f3 == MEM_B) || (f3 == MEM_H) || (f3 == MEM_W) ||
            (!we && ((f3 == MEM_BU) || (f3 == MEM_HU)));
    misal = (((f3 == MEM_H) || (f3 == MEM_HU)) && addr_lo[0]) ||
            ((f3 == MEM_W) && (addr_lo != 2'b00));
    if (!legal) return LSU_EXC_ILLEGAL;
    if (misal) return we ? LSU_EXC_STORE_MISALIGN : LSU_EXC_LOAD_MISALIGN;
    return LSU_EXC_NONE;
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      MEM_B, MEM_BU: lsu_be = 4'b0001 << addr_lo;
      MEM_H, MEM_HU: lsu_be = 4'b0011 << addr_lo;
      default:       lsu_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      MEM_B:   lsu_wdata = {4{d[7:0]}};
      MEM_H:   lsu_wdata = {2{d[15:0]}};
      default: lsu_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Load data aligner: selects the addressed byte/half lane and sign/zero-extends it.
// Purely combinational; no backpressure.
module riscv_load_align
  import riscv_constants::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr_lo, 3'b000} +: 8];
    half_lane = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      MEM_B:   data = {{24{byte_lane[7]}}, byte_lane};
      MEM_BU:  data = {24'h000000, byte_lane};
      MEM_H:   data = {{16{half_lane[15]}}, half_lane};
      MEM_HU:  data = {16'h0000, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one op per handshake, request/grant/response on dbus; rsp 3 cycles after accept minimum.
// req_ready drops from accept until the response cycle ends; dbus request holds stable until gnt.
module riscv_lsu
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int BE_WIDTH    = WORD_LENGTH / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [WORD_LENGTH-1:0] rdata,
  output logic                   exc_valid,
  output logic [1:0]             exc_cause,
  output logic                   dbus_req,
  input  logic                   dbus_gnt,
  output logic                   dbus_we,
  output logic [WORD_LENGTH-1:0] dbus_addr,
  output logic [BE_WIDTH-1:0]    dbus_be,
  output logic [WORD_LENGTH-1:0] dbus_wdata,
  input  logic                   dbus_rvalid,
  input  logic [WORD_LENGTH-1:0] dbus_rdata
);

  lsu_state_e             state;
  logic                   op_we;
  logic [2:0]             op_funct3;
  logic [1:0]             op_addr_lo;
  logic [WORD_LENGTH-1:0] load_data;
  lsu_exc_e               chk;

  assign chk = lsu_check(req_we, req_funct3, req_addr[1:0]);

  riscv_load_align u_align (
    .funct3  (op_funct3),
    .addr_lo (op_addr_lo),
    .word    (dbus_rdata),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LSU_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rdata      <= '0;
      exc_valid  <= 1'b0;
      exc_cause  <= 2'b00;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      op_we      <= 1'b0;
      op_funct3  <= 3'b000;
      op_addr_lo <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= 2'b00;
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            if (chk != LSU_EXC_NONE) begin
              exc_valid <= 1'b1;
              exc_cause <= chk;
            end else begin
              state      <= LSU_REQ;
              req_ready  <= 1'b0;
              op_we      <= req_we;
              op_funct3  <= req_funct3;
              op_addr_lo <= req_addr[1:0];
              dbus_req   <= 1'b1;
              dbus_we    <= req_we;
              dbus_addr  <= {req_addr[WORD_LENGTH-1:2], 2'b00};
              dbus_be    <= lsu_be(req_funct3, req_addr[1:0]);
              dbus_wdata <= lsu_wdata(req_funct3, req_wdata);
            end
          end
        end
        LSU_REQ: begin
          if (dbus_gnt) begin
            state      <= LSU_WAIT;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
          end
        end
        // rvalid in the grant cycle is ignored: only WAIT samples it.
        LSU_WAIT: begin
          if (dbus_rvalid) begin
            state     <= LSU_RESP;
            rsp_valid <= 1'b1;
            rdata     <= op_we ? '0 : load_data;
          end
        end
        LSU_RESP: begin
          state     <= LSU_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
